// File: rtl/sound_bus_ctrl.sv
// Sound-CPU bus controller: address decode to registered active-low selects, wait-state FSM and main/sound mailbox.
// Optional sticky overflow flags in the status register are enabled by defining SOUND_MAIL_OVF_EN.
module sound_bus_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int ROM_SEL_W  = 2,
    parameter int ROM_WAIT   = 0,
    parameter int YM_WAIT    = 3,
    parameter int MAIL_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic                    rdy,
    output logic [2**ROM_SEL_W-2:0] srom_l,
    output logic [1:0]              sram_l,
    output logic                    sndext_l,
    output logic                    ym_cs_l,
    output logic                    sio_rd_l,
    output logic                    sio_wr_l,
    output logic                    csnd_l,
    input  logic                    main_wr,
    input  logic [7:0]              main_din,
    input  logic                    main_rd,
    output logic [7:0]              main_dout,
    output logic                    main_pending,
    output logic                    snd_irq_l
);

    localparam int NROM     = 2**ROM_SEL_W - 1;
    localparam int MAX_WAIT = (YM_WAIT > ROM_WAIT) ? YM_WAIT : ROM_WAIT;
    localparam int WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int PTR_W    = (MAIL_DEPTH > 1) ? $clog2(MAIL_DEPTH) : 1;
    localparam int CNT_W    = $clog2(MAIL_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_HOLD} state_e;

    typedef enum logic [3:0] {
        DEV_ROM, DEV_SRAM0, DEV_SRAM1, DEV_EXT, DEV_YM,
        DEV_MAIL, DEV_SIO, DEV_STAT, DEV_CSND, DEV_NONE
    } dev_e;

    typedef struct packed {
        logic [NROM-1:0] rom;
        logic [1:0]      sram;
        logic            ext;
        logic            ym;
        logic            sio_rd;
        logic            sio_wr;
        logic            csnd;
    } sel_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ROM_SEL_W-1:0] top;
    logic [1:0]           mid;
    logic [2:0]           sub;
    logic                 req;
    logic                 wr_live;
    dev_e                 dev_live;
    logic [WAIT_W-1:0]    wait_live;
    sel_t                 sel_live;
    logic                 unused_addr;

    assign top         = addr[ADDR_W-1 -: ROM_SEL_W];
    assign mid         = addr[ADDR_W-ROM_SEL_W-1 -: 2];
    assign sub         = addr[6:4];
    assign req         = rd | wr;
    assign wr_live     = wr & ~rd;
    assign unused_addr = ^{addr[ADDR_W-ROM_SEL_W-3:7], addr[3:0]};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        dev_live = DEV_NONE;
        if (top != '0) begin
            dev_live = DEV_ROM;
        end else begin
            case (mid)
                2'd0: dev_live = DEV_SRAM0;
                2'd1: dev_live = DEV_SRAM1;
                2'd2: dev_live = DEV_EXT;
                default: begin
                    case (sub)
                        3'd0:    dev_live = DEV_YM;
                        3'd1:    dev_live = DEV_MAIL;
                        3'd2:    dev_live = DEV_SIO;
                        3'd3:    dev_live = DEV_STAT;
                        3'd7:    dev_live = DEV_CSND;
                        default: dev_live = DEV_NONE;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        wait_live = '0;
        sel_live  = '0;
        case (dev_live)
            DEV_ROM: begin
                wait_live = WAIT_W'(ROM_WAIT);
                for (int k = 0; k < NROM; k++) begin
                    if (top == ROM_SEL_W'(k + 1)) sel_live.rom[k] = 1'b1;
                end
            end
            DEV_SRAM0: sel_live.sram[0] = 1'b1;
            DEV_SRAM1: sel_live.sram[1] = 1'b1;
            DEV_EXT:   sel_live.ext     = 1'b1;
            DEV_YM: begin
                wait_live   = WAIT_W'(YM_WAIT);
                sel_live.ym = 1'b1;
            end
            DEV_SIO: begin
                sel_live.sio_wr = wr_live;
                sel_live.sio_rd = ~wr_live;
            end
            DEV_CSND:  sel_live.csnd    = 1'b1;
            default:   sel_live         = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    sel_t              sel_q, sel_d;
    logic              rdy_q, rdy_d;
    dev_e              dev_q;
    logic              wr_q;
    logic [7:0]        din_q;
    logic              fire;
    dev_e              cur_dev;
    logic              cur_wr;
    logic [7:0]        cur_din;

    // The side effect fires on the edge that makes rdy visible, so dout is valid together with rdy.
    assign fire = ((state_q == ST_IDLE) && req && (wait_live == '0)) ||
                  ((state_q == ST_ACCESS) && (cnt_q == WAIT_W'(1)));

    assign cur_dev = (state_q == ST_IDLE) ? dev_live : dev_q;
    assign cur_wr  = (state_q == ST_IDLE) ? wr_live  : wr_q;
    assign cur_din = (state_q == ST_IDLE) ? din      : din_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rdy_d   = rdy_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = wait_live;
                    sel_d   = sel_live;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_HOLD: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fire) rdy_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            rdy_q   <= 1'b0;
            dev_q   <= DEV_NONE;
            wr_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rdy_q   <= rdy_d;
            if ((state_q == ST_IDLE) && req) begin
                dev_q <= dev_live;
                wr_q  <= wr_live;
                din_q <= din;
            end
        end
    end

    assign rdy      = rdy_q;
    assign srom_l   = ~sel_q.rom;
    assign sram_l   = ~sel_q.sram;
    assign sndext_l = ~sel_q.ext;
    assign ym_cs_l  = ~sel_q.ym;
    assign sio_rd_l = ~sel_q.sio_rd;
    assign sio_wr_l = ~sel_q.sio_wr;
    assign csnd_l   = ~sel_q.csnd;

    // ------------------------------------------------------------------
    // Mailbox: main-to-sound FIFO and sound-to-main latch
    // ------------------------------------------------------------------
    logic [7:0]       mem [MAIL_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q;
    logic [7:0]       dout_q;
    logic [7:0]       main_dout_q;
    logic             pending_q;
    logic             fifo_nonempty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    logic             latch_wr;
    logic [1:0]       ovf_bits;
    logic [7:0]       status;
    logic [7:0]       rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAIL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = (count_q != '0);
    assign fifo_full     = (count_q == CNT_W'(MAIL_DEPTH));
    assign pop           = fire && !cur_wr && (cur_dev == DEV_MAIL) && fifo_nonempty;
    assign latch_wr      = fire && cur_wr && (cur_dev == DEV_MAIL);
    // A push on a full FIFO still fits when the sound side frees a slot on the same edge.
    assign push_ok       = main_wr && (!fifo_full || pop);
    assign push_drop     = main_wr && !push_ok;
    assign status        = {4'b0000, ovf_bits, pending_q, fifo_nonempty};

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        rd_data = 8'hFF;
        case (cur_dev)
            DEV_MAIL: if (fifo_nonempty) rd_data = mem[rd_ptr_q];
            DEV_STAT: rd_data = status;
            default:  rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            irq_q       <= 1'b1;
            dout_q      <= 8'hFF;
            main_dout_q <= 8'h00;
            pending_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= (count_d == '0);
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (fire && !cur_wr) dout_q <= rd_data;
            if (latch_wr) begin
                main_dout_q <= cur_din;
                pending_q   <= 1'b1;
            end else if (main_rd) begin
                pending_q   <= 1'b0;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= main_din;
    end

`ifdef SOUND_MAIL_OVF_EN
    logic fifo_ovf_q;
    logic latch_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            fifo_ovf_q  <= 1'b0;
            latch_ovf_q <= 1'b0;
        end else begin
            if (fire && cur_wr && (cur_dev == DEV_STAT) && cur_din[0]) begin
                fifo_ovf_q  <= 1'b0;
                latch_ovf_q <= 1'b0;
            end
            if (push_drop)             fifo_ovf_q  <= 1'b1;
            if (latch_wr && pending_q) latch_ovf_q <= 1'b1;
        end
    end

    assign ovf_bits = {latch_ovf_q, fifo_ovf_q};
`else
    logic unused_ovf;
    assign unused_ovf = push_drop;
    assign ovf_bits   = 2'b00;
`endif

    assign dout         = dout_q;
    assign main_dout    = main_dout_q;
    assign main_pending = pending_q;
    assign snd_irq_l    = irq_q;

endmodule
